// File: rtl/note_sequencer_if.sv
// Control, pattern-write and channel-output bundle for the note sequencer.
// The master drives the table and playback controls; the slave is the sequencer.
interface note_sequencer_if #(
  parameter int FREQ_W = 12,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_sel;
  logic [FREQ_W-1:0] wr_data;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] last_step;
  logic [FREQ_W-1:0] freq1;
  logic [FREQ_W-1:0] freq2;
  logic [FREQ_W-1:0] freq3;
  logic [FREQ_W-1:0] freq4;
  logic [ADDR_W-1:0] step;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_sel, wr_data, start, stop, loop_en, last_step,
    input  freq1, freq2, freq3, freq4, step, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_sel, wr_data, start, stop, loop_en, last_step,
    output freq1, freq2, freq3, freq4, step, busy, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Step sequencer feeding the four channel frequency words from a programmable
// pattern table; each step holds four frequency words and a duration in ticks.
//
//   state | meaning
//   IDLE  | outputs silent, waiting for start
//   PLAY  | stepping through the table, freqs latched on step entry
module note_sequencer #(
  parameter int FREQ_W   = 12,
  parameter int ADDR_W   = 4,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 50000
) (
  input logic             clk,
  input logic             reset_n,
  note_sequencer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PS_W  = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [FREQ_W-1:0] freq_tab [4][DEPTH];
  logic [DUR_W-1:0]  dur_tab  [DEPTH];
  logic [FREQ_W-1:0] freq_q   [4];
  logic [ADDR_W-1:0] step_q;
  logic [PS_W-1:0]   presc;
  logic [DUR_W-1:0]  dur_cnt;
  logic              done_q;

  logic              tick, last_tick;
  logic              enter, go_idle, done_nxt;
  logic [ADDR_W-1:0] enter_idx;

  wire unused_wr_data = &{1'b0, bus.wr_data[FREQ_W-1:DUR_W]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int c = 0; c < 4; c++) freq_tab[c][i] <= '0;
        dur_tab[i] <= '0;
      end
    end else if (bus.wr_en) begin
      if (!bus.wr_sel[2]) freq_tab[bus.wr_sel[1:0]][bus.wr_addr] <= bus.wr_data;
      else if (bus.wr_sel == 3'd4) dur_tab[bus.wr_addr] <= bus.wr_data[DUR_W-1:0];
    end
  end

  // A duration of 0 or 1 both end the step on its first tick.
  always_comb begin
    tick      = (state == PLAY) && (presc == PS_MAX);
    last_tick = tick && (dur_cnt <= DUR_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    enter_idx = '0;
    go_idle   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.stop) begin
          go_idle = 1'b1;
        end else if (bus.start) begin
          state_nxt = PLAY;
          enter     = 1'b1;
        end
      end
      PLAY: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          go_idle   = 1'b1;
        end else if (bus.start) begin
          enter = 1'b1;
        end else if (last_tick) begin
          if (step_q != bus.last_step) begin
            enter     = 1'b1;
            enter_idx = step_q + ADDR_W'(1);
          end else if (bus.loop_en) begin
            enter = 1'b1;
          end else begin
            state_nxt = IDLE;
            go_idle   = 1'b1;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 4; c++) freq_q[c] <= '0;
      step_q  <= '0;
      presc   <= '0;
      dur_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (go_idle) begin
        for (int c = 0; c < 4; c++) freq_q[c] <= '0;
        step_q  <= '0;
        presc   <= '0;
        dur_cnt <= '0;
      end else if (enter) begin
        for (int c = 0; c < 4; c++) freq_q[c] <= freq_tab[c][enter_idx];
        step_q  <= enter_idx;
        presc   <= '0;
        dur_cnt <= dur_tab[enter_idx];
      end else if (state == PLAY) begin
        if (tick) begin
          presc   <= '0;
          dur_cnt <= dur_cnt - DUR_W'(1);
        end else begin
          presc <= presc + PS_W'(1);
        end
      end
    end
  end

  assign bus.freq1 = freq_q[0];
  assign bus.freq2 = freq_q[1];
  assign bus.freq3 = freq_q[2];
  assign bus.freq4 = freq_q[3];
  assign bus.step  = step_q;
  assign bus.busy  = (state == PLAY);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboarded bench for note_sequencer with a 4-cycle tick: stimulus queues the
// expected output changes and their spacing, a negedge monitor pops and compares.
module tb_note_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  note_sequencer_if #(.FREQ_W(12), .ADDR_W(4)) bus ();

  note_sequencer #(.FREQ_W(12), .ADDR_W(4), .DUR_W(8), .TICK_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [11:0] f1, f2, f3, f4;
    logic [3:0]  step;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    obs_t o;
    int   gap;   // cycles since previous output change; 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t last_obs = '0;
  int   gap_cnt  = 0;

  function automatic obs_t cur_obs();
    obs_t o;
    o.f1 = bus.freq1; o.f2 = bus.freq2; o.f3 = bus.freq3; o.f4 = bus.freq4;
    o.step = bus.step; o.busy = bus.busy; o.done = bus.done;
    return o;
  endfunction

  function automatic obs_t mk(input int f1, input int f2, input int st,
                              input bit busy, input bit done);
    obs_t o;
    o = '0;
    o.f1 = 12'(f1); o.f2 = 12'(f2); o.step = 4'(st); o.busy = busy; o.done = done;
    return o;
  endfunction

  task automatic expect_chg(input obs_t o, input int gap);
    exp_t e;
    e.o = o; e.gap = gap;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    obs_t o;
    exp_t e;
    if (!reset_n) begin
      last_obs = '0;
      gap_cnt  = 0;
    end else begin
      gap_cnt++;
      o = cur_obs();
      if (o != last_obs) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change at %0t: got %h, none expected", $time, o);
        end else begin
          e = exp_q.pop_front();
          if (o != e.o) begin
            n_fail++;
            $display("FAIL outputs at %0t: got %h, want %h", $time, o, e.o);
          end
          if (e.gap != 0) begin
            n_checks++;
            if (gap_cnt != e.gap) begin
              n_fail++;
              $display("FAIL step_timing at %0t: got %0d cycles, want %0d", $time, gap_cnt, e.gap);
            end
          end
        end
        last_obs = o;
        gap_cnt  = 0;
      end
    end
  end

  task automatic check_now(input string name, input obs_t want);
    obs_t o;
    o = cur_obs();
    n_checks++;
    if (o != want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, o, want);
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d pending expected changes, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wr(input int addr, input int sel, input int data);
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'(addr); bus.wr_sel = 3'(sel); bus.wr_data = 12'(data);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  // Each pulse task returns 1ns after the edge that sampled the pulse.
  task automatic pulse(input bit s, input bit p);
    @(posedge clk); #1;
    bus.start = s; bus.stop = p;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_sel = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0; bus.last_step = '0;
    #23;
    check_now("reset_state", '0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // one-shot: 100 for 2 ticks, 200 for 1 tick, then done
    wr(0, 0, 100); wr(0, 4, 2); wr(1, 0, 200); wr(1, 4, 1);
    bus.last_step = 4'd1; bus.loop_en = 1'b0;
    expect_chg(mk(100, 0, 0, 1, 0), 0);
    expect_chg(mk(200, 0, 1, 1, 0), 8);
    expect_chg(mk(0,   0, 0, 0, 1), 4);
    expect_chg(mk(0,   0, 0, 0, 0), 1);
    pulse(1, 0);
    repeat (20) @(posedge clk);
    check_drained("oneshot_sequence");

    // looped, then start+stop together: stop wins, no done
    bus.loop_en = 1'b1;
    expect_chg(mk(100, 0, 0, 1, 0), 0);
    expect_chg(mk(200, 0, 1, 1, 0), 8);
    expect_chg(mk(100, 0, 0, 1, 0), 4);
    expect_chg(mk(200, 0, 1, 1, 0), 8);
    expect_chg(mk(100, 0, 0, 1, 0), 4);
    expect_chg(mk(0,   0, 0, 0, 0), 4);
    pulse(1, 0);
    repeat (26) @(posedge clk);
    pulse(1, 1);
    repeat (10) @(posedge clk);
    check_drained("loop_then_stop");

    // duration 0 behaves as a single tick
    bus.loop_en = 1'b0;
    wr(0, 4, 0);
    expect_chg(mk(100, 0, 0, 1, 0), 0);
    expect_chg(mk(200, 0, 1, 1, 0), 4);
    expect_chg(mk(0,   0, 0, 0, 1), 4);
    expect_chg(mk(0,   0, 0, 0, 0), 1);
    pulse(1, 0);
    repeat (15) @(posedge clk);
    check_drained("dur_zero");

    // freq2 written to the playing step is heard only on re-entry
    wr(0, 4, 2);
    bus.loop_en = 1'b1;
    expect_chg(mk(100, 0,  0, 1, 0), 0);
    expect_chg(mk(200, 0,  1, 1, 0), 8);
    expect_chg(mk(100, 55, 0, 1, 0), 4);
    expect_chg(mk(0,   0,  0, 0, 0), 2);
    pulse(1, 0);
    wr(0, 1, 55);
    repeat (10) @(posedge clk);
    pulse(0, 1);
    repeat (6) @(posedge clk);
    check_drained("write_current_step");

    // asynchronous reset in the middle of play
    expect_chg(mk(100, 55, 0, 1, 0), 0);
    pulse(1, 0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_now("reset_mid_play", '0);
    check_drained("reset_mid_play_start");
    #20 reset_n = 1'b1;

    // cleared table: silent steps of one tick each, then done
    bus.loop_en = 1'b0; bus.last_step = 4'd1;
    expect_chg(mk(0, 0, 0, 1, 0), 0);
    expect_chg(mk(0, 0, 1, 1, 0), 4);
    expect_chg(mk(0, 0, 0, 0, 1), 4);
    expect_chg(mk(0, 0, 0, 0, 0), 1);
    pulse(1, 0);
    repeat (15) @(posedge clk);
    check_drained("cold_table");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
